// File: rtl/dispatch_queue.sv
// Bundle dispatch queue: a DEPTH-entry FIFO of issue bundles whose head lanes are
// handed out to per-lane arithmetic / load-store ports and one shared branch port.
module dispatch_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 7,
  parameter int WBA_W  = 5
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES-1:0]          in_en_i,
  input  logic [2*LANES-1:0]        in_type_i,
  input  logic [LANES-1:0]          in_isWb_i,
  input  logic [WBA_W*LANES-1:0]    in_wbAddr_i,
  input  logic [OPC_W*LANES-1:0]    in_opCode_i,
  input  logic [DATA_W*LANES-1:0]   in_pOperand_i,
  input  logic [DATA_W*LANES-1:0]   in_sOperand_i,
  input  logic [2*LANES-1:0]        in_opStat_i,
  output logic [LANES-1:0]          arith_valid_o,
  input  logic [LANES-1:0]          arith_ready_i,
  output logic [LANES-1:0]          arith_isWb_o,
  output logic [WBA_W*LANES-1:0]    arith_wbAddr_o,
  output logic [OPC_W*LANES-1:0]    arith_opCode_o,
  output logic [DATA_W*LANES-1:0]   arith_pOperand_o,
  output logic [DATA_W*LANES-1:0]   arith_sOperand_o,
  output logic [LANES-1:0]          ls_valid_o,
  input  logic [LANES-1:0]          ls_ready_i,
  output logic [LANES-1:0]          ls_isWb_o,
  output logic [WBA_W*LANES-1:0]    ls_wbAddr_o,
  output logic [OPC_W*LANES-1:0]    ls_opCode_o,
  output logic [DATA_W*LANES-1:0]   ls_pOperand_o,
  output logic [DATA_W*LANES-1:0]   ls_sOperand_o,
  output logic                      br_valid_o,
  input  logic                      br_ready_i,
  output logic [OPC_W-1:0]          br_opCode_o,
  output logic [DATA_W-1:0]         br_pOperand_o,
  output logic [DATA_W-1:0]         br_sOperand_o,
  output logic [1:0]                br_opStat_o,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] br_lane_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BLW = (LANES > 1) ? $clog2(LANES) : 1;

  // Bundle storage; data is never reset, visibility is gated by the valids.
  logic [LANES-1:0]        need_mem [DEPTH];
  logic [2*LANES-1:0]      type_mem [DEPTH];
  logic [LANES-1:0]        wb_mem   [DEPTH];
  logic [WBA_W*LANES-1:0]  wba_mem  [DEPTH];
  logic [OPC_W*LANES-1:0]  opc_mem  [DEPTH];
  logic [DATA_W*LANES-1:0] pa_mem   [DEPTH];
  logic [DATA_W*LANES-1:0] sa_mem   [DEPTH];
  logic [2*LANES-1:0]      stat_mem [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [LANES-1:0] done_q;

  logic             nonempty, push, pop;
  logic [LANES-1:0] in_need, pend, fire;
  logic [LANES-1:0] arith_v, ls_v;
  logic             br_v;
  logic [BLW-1:0]   br_sel;

  logic [LANES-1:0]        h_need, h_wb;
  logic [2*LANES-1:0]      h_type, h_stat;
  logic [WBA_W*LANES-1:0]  h_wba;
  logic [OPC_W*LANES-1:0]  h_opc;
  logic [DATA_W*LANES-1:0] h_pa, h_sa;

  assign nonempty   = (count_q != '0);
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o & ~flush_i & ~reset_i;
  assign count_o    = count_q;

  assign h_need = need_mem[rd_ptr];
  assign h_type = type_mem[rd_ptr];
  assign h_wb   = wb_mem[rd_ptr];
  assign h_wba  = wba_mem[rd_ptr];
  assign h_opc  = opc_mem[rd_ptr];
  assign h_pa   = pa_mem[rd_ptr];
  assign h_sa   = sa_mem[rd_ptr];
  assign h_stat = stat_mem[rd_ptr];

  // Disabled and nop lanes are considered done the moment they are enqueued.
  always_comb begin
    in_need = '0;
    for (int l = 0; l < LANES; l++)
      in_need[l] = in_en_i[l] & (in_type_i[2*l +: 2] != 2'd3);
  end

  assign pend = h_need & ~done_q & {LANES{nonempty}};

  always_comb begin
    arith_v = '0;
    ls_v    = '0;
    br_v    = 1'b0;
    br_sel  = '0;
    fire    = '0;
    for (int l = 0; l < LANES; l++) begin
      if (h_type[2*l +: 2] == 2'd0) arith_v[l] = pend[l];
      if (h_type[2*l +: 2] == 2'd1) ls_v[l]    = pend[l];
      if (h_type[2*l +: 2] == 2'd2 && pend[l] && !br_v) begin
        br_v   = 1'b1;
        br_sel = BLW'(l);
      end
    end
    for (int l = 0; l < LANES; l++)
      fire[l] = (arith_v[l] & arith_ready_i[l]) | (ls_v[l] & ls_ready_i[l]) |
                (br_v & br_ready_i & (br_sel == BLW'(l)));
  end

  assign pop = nonempty & (&(done_q | fire | ~h_need));

  always_comb begin
    arith_isWb_o = '0; arith_wbAddr_o = '0; arith_opCode_o = '0;
    arith_pOperand_o = '0; arith_sOperand_o = '0;
    ls_isWb_o = '0; ls_wbAddr_o = '0; ls_opCode_o = '0;
    ls_pOperand_o = '0; ls_sOperand_o = '0;
    br_opCode_o = '0; br_pOperand_o = '0; br_sOperand_o = '0; br_opStat_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (arith_v[l]) begin
        arith_isWb_o[l]                      = h_wb[l];
        arith_wbAddr_o[l*WBA_W +: WBA_W]     = h_wba[l*WBA_W +: WBA_W];
        arith_opCode_o[l*OPC_W +: OPC_W]     = h_opc[l*OPC_W +: OPC_W];
        arith_pOperand_o[l*DATA_W +: DATA_W] = h_pa[l*DATA_W +: DATA_W];
        arith_sOperand_o[l*DATA_W +: DATA_W] = h_sa[l*DATA_W +: DATA_W];
      end
      if (ls_v[l]) begin
        ls_isWb_o[l]                      = h_wb[l];
        ls_wbAddr_o[l*WBA_W +: WBA_W]     = h_wba[l*WBA_W +: WBA_W];
        ls_opCode_o[l*OPC_W +: OPC_W]     = h_opc[l*OPC_W +: OPC_W];
        ls_pOperand_o[l*DATA_W +: DATA_W] = h_pa[l*DATA_W +: DATA_W];
        ls_sOperand_o[l*DATA_W +: DATA_W] = h_sa[l*DATA_W +: DATA_W];
      end
      if (br_v && br_sel == BLW'(l)) begin
        br_opCode_o   = h_opc[l*OPC_W +: OPC_W];
        br_pOperand_o = h_pa[l*DATA_W +: DATA_W];
        br_sOperand_o = h_sa[l*DATA_W +: DATA_W];
        br_opStat_o   = h_stat[2*l +: 2];
      end
    end
  end

  assign arith_valid_o = arith_v;
  assign ls_valid_o    = ls_v;
  assign br_valid_o    = br_v;
  assign br_lane_o     = br_sel;

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      done_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        done_q <= '0;
      end else begin
        done_q <= done_q | fire;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      need_mem[wr_ptr] <= in_need;
      type_mem[wr_ptr] <= in_type_i;
      wb_mem[wr_ptr]   <= in_isWb_i;
      wba_mem[wr_ptr]  <= in_wbAddr_i;
      opc_mem[wr_ptr]  <= in_opCode_i;
      pa_mem[wr_ptr]   <= in_pOperand_i;
      sa_mem[wr_ptr]   <= in_sOperand_i;
      stat_mem[wr_ptr] <= in_opStat_i;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (LANES=2, DEPTH=4, DATA_W=16, OPC_W=7, WBA_W=5).
module tb_dispatch_queue;
  logic        clk = 1'b0;
  logic        reset_i, flush_i, in_valid_i, in_ready_o;
  logic [1:0]  in_en_i, in_isWb_i;
  logic [3:0]  in_type_i, in_opStat_i;
  logic [9:0]  in_wbAddr_i;
  logic [13:0] in_opCode_i;
  logic [31:0] in_pOperand_i, in_sOperand_i;
  logic [1:0]  arith_valid_o, arith_ready_i, arith_isWb_o;
  logic [9:0]  arith_wbAddr_o;
  logic [13:0] arith_opCode_o;
  logic [31:0] arith_pOperand_o, arith_sOperand_o;
  logic [1:0]  ls_valid_o, ls_ready_i, ls_isWb_o;
  logic [9:0]  ls_wbAddr_o;
  logic [13:0] ls_opCode_o;
  logic [31:0] ls_pOperand_o, ls_sOperand_o;
  logic        br_valid_o, br_ready_i;
  logic [6:0]  br_opCode_o;
  logic [15:0] br_pOperand_o, br_sOperand_o;
  logic [1:0]  br_opStat_o;
  logic [0:0]  br_lane_o;
  logic [2:0]  count_o;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dispatch_queue #(.LANES(2), .DEPTH(4), .DATA_W(16), .OPC_W(7), .WBA_W(5)) dut (
    .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_en_i(in_en_i),
    .in_type_i(in_type_i), .in_isWb_i(in_isWb_i), .in_wbAddr_i(in_wbAddr_i),
    .in_opCode_i(in_opCode_i), .in_pOperand_i(in_pOperand_i),
    .in_sOperand_i(in_sOperand_i), .in_opStat_i(in_opStat_i),
    .arith_valid_o(arith_valid_o), .arith_ready_i(arith_ready_i),
    .arith_isWb_o(arith_isWb_o), .arith_wbAddr_o(arith_wbAddr_o),
    .arith_opCode_o(arith_opCode_o), .arith_pOperand_o(arith_pOperand_o),
    .arith_sOperand_o(arith_sOperand_o),
    .ls_valid_o(ls_valid_o), .ls_ready_i(ls_ready_i), .ls_isWb_o(ls_isWb_o),
    .ls_wbAddr_o(ls_wbAddr_o), .ls_opCode_o(ls_opCode_o),
    .ls_pOperand_o(ls_pOperand_o), .ls_sOperand_o(ls_sOperand_o),
    .br_valid_o(br_valid_o), .br_ready_i(br_ready_i), .br_opCode_o(br_opCode_o),
    .br_pOperand_o(br_pOperand_o), .br_sOperand_o(br_sOperand_o),
    .br_opStat_o(br_opStat_o), .br_lane_o(br_lane_o), .count_o(count_o)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    in_valid_i = 0; flush_i = 0; in_en_i = 0; in_type_i = 0; in_isWb_i = 0;
    in_wbAddr_i = 0; in_opCode_i = 0; in_pOperand_i = 0; in_sOperand_i = 0; in_opStat_i = 0;
  endtask

  task automatic set_lane(input int l, input logic [1:0] typ, input logic [6:0] opc,
                          input logic [15:0] p, input logic [15:0] s);
    in_en_i[l] = 1'b1;
    in_type_i[2*l +: 2] = typ;
    in_isWb_i[l] = 1'b1;
    in_wbAddr_i[5*l +: 5] = 5'(l + 3);
    in_opCode_i[7*l +: 7] = opc;
    in_pOperand_i[16*l +: 16] = p;
    in_sOperand_i[16*l +: 16] = s;
    in_opStat_i[2*l +: 2] = 2'(l + 1);
  endtask

  task automatic test_reset;
    reset_i = 1; clear_in; arith_ready_i = 0; ls_ready_i = 0; br_ready_i = 0;
    step; step; reset_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready_o); end
    n_cmp++; if ({arith_valid_o, ls_valid_o, br_valid_o} !== 5'b0) begin n_bad++; $display("FAIL rst_valids: got %b want 0", {arith_valid_o, ls_valid_o, br_valid_o}); end
    n_cmp++; if (arith_opCode_o !== 14'd0 || br_lane_o !== 1'b0) begin n_bad++; $display("FAIL rst_payload: got %h/%b want 0/0", arith_opCode_o, br_lane_o); end
    step;
  endtask

  task automatic test_arith_ls;
    clear_in; set_lane(0, 2'd0, 7'h05, 16'd3, 16'd4); set_lane(1, 2'd1, 7'h11, 16'd7, 16'd8);
    in_valid_i = 1; arith_ready_i = 2'b11; ls_ready_i = 2'b11; br_ready_i = 1;
    @(negedge clk);
    n_cmp++; if (arith_valid_o !== 2'b00) begin n_bad++; $display("FAIL al_early: got %b want 00", arith_valid_o); end
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd1) begin n_bad++; $display("FAIL al_count1: got %0d want 1", count_o); end
    n_cmp++; if (arith_valid_o !== 2'b01 || ls_valid_o !== 2'b10) begin n_bad++; $display("FAIL al_valids: got %b/%b want 01/10", arith_valid_o, ls_valid_o); end
    n_cmp++; if (arith_opCode_o !== 14'h0005 || arith_pOperand_o !== 32'd3 || arith_sOperand_o !== 32'd4) begin n_bad++; $display("FAIL al_arith_pay: got %h %h %h want 0005 3 4", arith_opCode_o, arith_pOperand_o, arith_sOperand_o); end
    n_cmp++; if (ls_opCode_o !== {7'h11, 7'h00} || ls_wbAddr_o !== {5'd4, 5'd0} || arith_isWb_o !== 2'b01) begin n_bad++; $display("FAIL al_ls_pay: got %h %h %b want 0880 080 01", ls_opCode_o, ls_wbAddr_o, arith_isWb_o); end
    step;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || arith_valid_o !== 2'b00 || ls_valid_o !== 2'b00) begin n_bad++; $display("FAIL al_pop: got cnt %0d %b %b want 0 00 00", count_o, arith_valid_o, ls_valid_o); end
    step;
  endtask

  task automatic test_branch;
    clear_in; set_lane(0, 2'd2, 7'h21, 16'h10, 16'h11); set_lane(1, 2'd2, 7'h22, 16'h20, 16'h21);
    in_valid_i = 1; br_ready_i = 1;
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (br_valid_o !== 1'b1 || br_lane_o !== 1'b0 || br_opCode_o !== 7'h21 || br_opStat_o !== 2'd1 || br_pOperand_o !== 16'h10) begin n_bad++; $display("FAIL br_first: got v%b l%b op%h st%0d p%h want 1 0 21 1 10", br_valid_o, br_lane_o, br_opCode_o, br_opStat_o, br_pOperand_o); end
    step;
    @(negedge clk);
    n_cmp++; if (br_valid_o !== 1'b1 || br_lane_o !== 1'b1 || br_opCode_o !== 7'h22 || br_opStat_o !== 2'd2 || count_o !== 3'd1) begin n_bad++; $display("FAIL br_second: got v%b l%b op%h st%0d c%0d want 1 1 22 2 1", br_valid_o, br_lane_o, br_opCode_o, br_opStat_o, count_o); end
    step;
    @(negedge clk);
    n_cmp++; if (br_valid_o !== 1'b0 || count_o !== 3'd0) begin n_bad++; $display("FAIL br_pop: got v%b c%0d want 0 0", br_valid_o, count_o); end
    step;
  endtask

  task automatic test_nop;
    clear_in; in_en_i = 2'b01; in_type_i = 4'b0011; in_valid_i = 1;
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd1 || {arith_valid_o, ls_valid_o, br_valid_o} !== 5'b0) begin n_bad++; $display("FAIL nop_hold: got c%0d v%b want 1 0", count_o, {arith_valid_o, ls_valid_o, br_valid_o}); end
    step;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL nop_pop: got %0d want 0", count_o); end
    step;
  endtask

  task automatic test_full;
    arith_ready_i = 0; ls_ready_i = 0; br_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      clear_in; set_lane(0, 2'd0, 7'(k + 1), 16'(k), 16'd0); in_valid_i = 1;
      step;
    end
    clear_in; set_lane(0, 2'd0, 7'h09, 16'd9, 16'd9); in_valid_i = 1;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin n_bad++; $display("FAIL full: got c%0d r%b want 4 0", count_o, in_ready_o); end
    step; in_valid_i = 0; arith_ready_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (arith_valid_o !== 2'b01 || arith_opCode_o[6:0] !== 7'(k + 1) || count_o !== 3'(4 - k)) begin n_bad++; $display("FAIL drain%0d: got v%b op%h c%0d want 01 %h %0d", k, arith_valid_o, arith_opCode_o[6:0], count_o, k + 1, 4 - k); end
      step;
    end
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || arith_valid_o !== 2'b00) begin n_bad++; $display("FAIL drain_end: got c%0d v%b want 0 00", count_o, arith_valid_o); end
    step;
  endtask

  task automatic test_back_to_back;
    arith_ready_i = 2'b11;
    clear_in; set_lane(0, 2'd0, 7'h41, 16'd1, 16'd1); in_valid_i = 1;
    step; in_opCode_i[6:0] = 7'h42;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd1 || arith_opCode_o[6:0] !== 7'h41) begin n_bad++; $display("FAIL b2b_a: got c%0d op%h want 1 41", count_o, arith_opCode_o[6:0]); end
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd1 || arith_valid_o !== 2'b01 || arith_opCode_o[6:0] !== 7'h42) begin n_bad++; $display("FAIL b2b_b: got c%0d v%b op%h want 1 01 42", count_o, arith_valid_o, arith_opCode_o[6:0]); end
    step;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL b2b_end: got %0d want 0", count_o); end
    step;
  endtask

  task automatic test_stall;
    clear_in; set_lane(0, 2'd0, 7'h22, 16'h1234, 16'hABCD); set_lane(1, 2'd1, 7'h33, 16'd5, 16'd6);
    arith_ready_i = 0; ls_ready_i = 2'b10; in_valid_i = 1;
    step; in_valid_i = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) arith_ready_i = 2'b01;
      @(negedge clk);
      n_cmp++; if (arith_valid_o !== 2'b01 || arith_opCode_o[6:0] !== 7'h22 || arith_pOperand_o[15:0] !== 16'h1234 || arith_sOperand_o[15:0] !== 16'hABCD || count_o !== 3'd1) begin n_bad++; $display("FAIL stall_arith%0d: got v%b op%h p%h s%h c%0d want 01 22 1234 abcd 1", c, arith_valid_o, arith_opCode_o[6:0], arith_pOperand_o[15:0], arith_sOperand_o[15:0], count_o); end
      n_cmp++; if (ls_valid_o !== ((c == 0) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL stall_ls%0d: got %b want %b", c, ls_valid_o, (c == 0) ? 2'b10 : 2'b00); end
      step;
    end
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || arith_valid_o !== 2'b00) begin n_bad++; $display("FAIL stall_pop: got c%0d v%b want 0 00", count_o, arith_valid_o); end
    step;
  endtask

  task automatic test_flush;
    clear_in; set_lane(0, 2'd0, 7'h50, 16'd1, 16'd2); set_lane(1, 2'd1, 7'h51, 16'd3, 16'd4);
    arith_ready_i = 0; ls_ready_i = 2'b10; in_valid_i = 1;
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (arith_valid_o !== 2'b01 || ls_valid_o !== 2'b10) begin n_bad++; $display("FAIL fl_pre: got %b/%b want 01/10", arith_valid_o, ls_valid_o); end
    step;
    clear_in; set_lane(0, 2'd1, 7'h60, 16'd9, 16'd9); in_valid_i = 1; flush_i = 1;
    step; clear_in;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || {arith_valid_o, ls_valid_o, br_valid_o} !== 5'b0 || in_ready_o !== 1'b1) begin n_bad++; $display("FAIL fl_empty: got c%0d v%b r%b want 0 0 1", count_o, {arith_valid_o, ls_valid_o, br_valid_o}, in_ready_o); end
    step;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || ls_valid_o !== 2'b00) begin n_bad++; $display("FAIL fl_dropped: got c%0d ls%b want 0 00", count_o, ls_valid_o); end
    step;
    ls_ready_i = 0; set_lane(1, 2'd1, 7'h52, 16'd1, 16'd1); in_valid_i = 1;
    step; in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (ls_valid_o !== 2'b10 || ls_opCode_o[13:7] !== 7'h52) begin n_bad++; $display("FAIL fl_fresh: got %b op%h want 10 52", ls_valid_o, ls_opCode_o[13:7]); end
    step; ls_ready_i = 2'b10;
    @(negedge clk);
    step;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL fl_fresh_pop: got %0d want 0", count_o); end
    step;
  endtask

  task automatic test_reset_mid;
    arith_ready_i = 0; ls_ready_i = 0; br_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      clear_in; set_lane(0, 2'd0, 7'(k + 16), 16'd5, 16'd6); set_lane(1, 2'd2, 7'h70, 16'd7, 16'd8);
      in_valid_i = 1;
      step;
    end
    in_valid_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd3 || br_valid_o !== 1'b1 || arith_valid_o !== 2'b01) begin n_bad++; $display("FAIL rm_queued: got c%0d b%b a%b want 3 1 01", count_o, br_valid_o, arith_valid_o); end
    step; reset_i = 1; flush_i = 1;
    step; reset_i = 0; flush_i = 0;
    @(negedge clk);
    n_cmp++; if (count_o !== 3'd0 || {arith_valid_o, ls_valid_o, br_valid_o} !== 5'b0 || in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rm_ctrl: got c%0d v%b r%b want 0 0 1", count_o, {arith_valid_o, ls_valid_o, br_valid_o}, in_ready_o); end
    n_cmp++; if (arith_opCode_o !== 14'd0 || br_opCode_o !== 7'd0 || br_lane_o !== 1'b0 || br_pOperand_o !== 16'd0) begin n_bad++; $display("FAIL rm_payload: got %h %h %b %h want 0 0 0 0", arith_opCode_o, br_opCode_o, br_lane_o, br_pOperand_o); end
    step;
  endtask

  initial begin
    test_reset;
    test_arith_ls;
    test_branch;
    test_nop;
    test_full;
    test_back_to_back;
    test_stall;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
